// File: rtl/mips32_test_sequencer.sv
// mips32_test_sequencer
//
// Loads a program/data image into the MIPS32 core's unified memory, releases
// the core from hold, waits for HALTED (or a RUN-cycle timeout), then reads
// back up to NUM_CHECKS result words and compares them against expected values.
//
// Ports:
//   clk1, rst_n          clock (rising edge), asynchronous active-low reset
//   start                begin a sequence; only sampled while IDLE or DONE
//   prog_valid/ready     load-word handshake; prog_ready is high only in LOAD
//   prog_addr/data/last  load word, its target address, final-beat marker
//   timeout_cycles       RUN-cycle limit, 0 disables the limit
//   chk_en/addr/data     per-slot enable, packed check addresses and expected values
//   mem_we/addr/wdata    memory port towards the core's unified memory
//   mem_rdata            memory read data, valid one cycle after mem_addr
//   core_run             1 releases the core, 0 holds it in reset
//   core_halted          core HALTED flag
//   busy/done            sequence in progress / finished (done held until next start)
//   pass/timed_out       result flags, meaningful while done
//   fail_idx             first failing check slot
//   cycle_count          RUN cycles consumed, saturating

module mips32_test_sequencer #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int NUM_CHECKS = 4,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                         clk1,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         prog_valid,
  output logic                         prog_ready,
  input  logic [ADDR_W-1:0]            prog_addr,
  input  logic [DATA_W-1:0]            prog_data,
  input  logic                         prog_last,
  input  logic [CNT_W-1:0]             timeout_cycles,
  input  logic [NUM_CHECKS-1:0]        chk_en,
  input  logic [NUM_CHECKS*ADDR_W-1:0] chk_addr,
  input  logic [NUM_CHECKS*DATA_W-1:0] chk_data,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         core_run,
  input  logic                         core_halted,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timed_out,
  output logic [IDX_W-1:0]             fail_idx,
  output logic [CNT_W-1:0]             cycle_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_CHK_RD  = 3'd3;
  localparam logic [2:0] ST_CHK_CMP = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
  logic             pass_q, pass_d;
  logic             timed_out_q, timed_out_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic             rd_found;
  logic [IDX_W-1:0] rd_slot;
  logic             more_after;
  logic             tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_W'(1);
  endfunction

  function automatic logic [ADDR_W-1:0] slot_addr(
    input logic [NUM_CHECKS*ADDR_W-1:0] vec,
    input logic [IDX_W-1:0]             idx
  );
    return vec[int'(idx)*ADDR_W +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] slot_data(
    input logic [NUM_CHECKS*DATA_W-1:0] vec,
    input logic [IDX_W-1:0]             idx
  );
    return vec[int'(idx)*DATA_W +: DATA_W];
  endfunction

  // Disabled slots are skipped combinationally so every enabled check costs
  // exactly one read cycle and one compare cycle. rd_slot is the lowest enabled
  // slot at or above the pointer; more_after says whether any enabled slot
  // lies beyond the pointer, so the last match can go straight to DONE.
  always_comb begin
    rd_found   = 1'b0;
    rd_slot    = '0;
    more_after = 1'b0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (chk_en[i] && (i >= int'(ptr_q))) begin
        rd_found = 1'b1;
        rd_slot  = IDX_W'(i);
      end
      if (chk_en[i] && (i > int'(ptr_q))) begin
        more_after = 1'b1;
      end
    end
  end

  // Fires on the last allowed RUN cycle so that the sequence ends after
  // exactly timeout_cycles RUN cycles.
  assign tmo_hit = (timeout_cycles != '0) &&
                   (cycle_count_q == timeout_cycles - CNT_W'(1));

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    fail_idx_d    = fail_idx_q;
    pass_d        = pass_q;
    timed_out_d   = timed_out_q;
    cycle_count_d = cycle_count_q;
    prog_ready    = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d       = ST_LOAD;
          ptr_d         = '0;
          fail_idx_d    = '0;
          pass_d        = 1'b0;
          timed_out_d   = 1'b0;
          cycle_count_d = '0;
        end
      end

      ST_LOAD: begin
        prog_ready = 1'b1;
        if (prog_valid) begin
          mem_we    = 1'b1;
          mem_addr  = prog_addr;
          mem_wdata = prog_data;
          if (prog_last) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        cycle_count_d = sat_inc(cycle_count_q);
        // HALTED has priority over a timeout landing in the same cycle.
        if (core_halted) begin
          state_d = ST_CHK_RD;
          ptr_d   = '0;
        end else if (tmo_hit) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b1;
          pass_d      = 1'b0;
        end
      end

      ST_CHK_RD: begin
        if (rd_found) begin
          mem_addr = slot_addr(chk_addr, rd_slot);
          ptr_d    = rd_slot;
          state_d  = ST_CHK_CMP;
        end else begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end
      end

      ST_CHK_CMP: begin
        // Keep the address stable while the read data is being compared.
        mem_addr = slot_addr(chk_addr, ptr_q);
        if (mem_rdata != slot_data(chk_data, ptr_q)) begin
          state_d    = ST_DONE;
          pass_d     = 1'b0;
          fail_idx_d = ptr_q;
        end else if (more_after) begin
          ptr_d   = ptr_q + IDX_W'(1);
          state_d = ST_CHK_RD;
        end else begin
          state_d = ST_DONE;
          pass_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= '0;
      fail_idx_q    <= '0;
      pass_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      fail_idx_q    <= fail_idx_d;
      pass_q        <= pass_d;
      timed_out_q   <= timed_out_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Status outputs decode straight from the state register, so an
  // asynchronous reset drops core_run and busy in the same instant.
  assign core_run    = (state_q == ST_RUN);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                       (state_q == ST_CHK_RD) || (state_q == ST_CHK_CMP);
  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;
  assign timed_out   = timed_out_q;
  assign fail_idx    = fail_idx_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mips32_test_sequencer.sv
// Testbench for mips32_test_sequencer: memory + stub core model, per-cycle
// timeline reference model, randomized program/check stimulus.
module tb_mips32_test_sequencer;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 10;
  localparam int NUM_CHECKS = 4;
  localparam int CNT_W      = 16;
  localparam int IDX_W      = 2;
  localparam int MEM_D      = 1 << ADDR_W;
  localparam int MAXC       = 64;

  localparam logic [31:0] FACT_IMG [11] = '{
    32'h8C01_00C8, 32'h2002_0001, 32'h1020_0004, 32'h0000_0000,
    32'h7041_1002, 32'h2021_FFFF, 32'h1420_FFFC, 32'h0000_0000,
    32'hAC02_00C6, 32'hFC00_0000, 32'h0000_0000};

  logic                         clk1 = 1'b0;
  logic                         rst_n, start, prog_valid, prog_ready, prog_last;
  logic [ADDR_W-1:0]            prog_addr;
  logic [DATA_W-1:0]            prog_data;
  logic [CNT_W-1:0]             timeout_cycles;
  logic [NUM_CHECKS-1:0]        chk_en;
  logic [NUM_CHECKS*ADDR_W-1:0] chk_addr;
  logic [NUM_CHECKS*DATA_W-1:0] chk_data;
  logic                         mem_we, core_run, core_halted, busy, done, pass, timed_out;
  logic [ADDR_W-1:0]            mem_addr;
  logic [DATA_W-1:0]            mem_wdata, mem_rdata;
  logic [IDX_W-1:0]             fail_idx;
  logic [CNT_W-1:0]             cycle_count;

  always #5 clk1 = ~clk1;

  mips32_test_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NUM_CHECKS), .CNT_W(CNT_W)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start),
    .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_last(prog_last), .timeout_cycles(timeout_cycles),
    .chk_en(chk_en), .chk_addr(chk_addr), .chk_data(chk_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .core_run(core_run), .core_halted(core_halted), .busy(busy), .done(done),
    .pass(pass), .timed_out(timed_out), .fail_idx(fail_idx), .cycle_count(cycle_count)
  );

  function automatic logic [31:0] fact32(input logic [31:0] n);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= 20; i++) begin
      if (32'(i) <= n) r = r * 32'(i);
    end
    return r;
  endfunction

  // Memory (synchronous read) and stub core: the core runs for halt_after
  // cycles, stores fact(Mem[200]) to Mem[198] and raises HALTED. halt_after=0
  // models a program without HLT. Held core: HALTED cleared.
  logic [DATA_W-1:0] mem [MEM_D];
  logic [DATA_W-1:0] rdata_q;
  logic              halted_q = 1'b0;
  int                run_cnt = 0;
  int                halt_after = 0;
  int                cyc = 0;

  assign mem_rdata   = rdata_q;
  assign core_halted = halted_q;

  always @(posedge clk1) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    rdata_q <= mem[mem_addr];
    if (!core_run) begin
      run_cnt  <= 0;
      halted_q <= 1'b0;
    end else begin
      run_cnt <= run_cnt + 1;
      if (halt_after != 0 && run_cnt + 1 == halt_after) begin
        halted_q <= 1'b1;
        mem[198] <= fact32(mem[200]);
      end
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load schedule (one entry per LOAD cycle) and beat list.
  logic              sv [MAXC];
  logic [ADDR_W-1:0] sa [MAXC];
  logic [DATA_W-1:0] sd [MAXC];
  logic              sl [MAXC];
  logic [ADDR_W-1:0] ba [16];
  logic [DATA_W-1:0] bd [16];
  int                nbeats;

  // Expected timeline: lc LOAD cycles, rr RUN cycles, cc_len check cycles, then DONE.
  int   lc, rr, cc_len, e_end, n_en, exp_fidx;
  int   en_list [NUM_CHECKS];
  logic exp_pass, exp_to;
  bit   active = 1'b0;
  int   start_cyc = 0;

  always @(negedge clk1) begin
    if (active) begin
      int k;
      int off;
      k = cyc - start_cyc;
      if (k < lc) begin
        chk("load_busy", 64'(busy), 64'(1));
        chk("load_run", 64'(core_run), 64'(0));
        chk("load_ready", 64'(prog_ready), 64'(1));
        chk("load_we", 64'(mem_we), 64'(sv[k]));
        if (sv[k]) begin
          chk("load_addr", 64'(mem_addr), 64'(sa[k]));
          chk("load_wdata", 64'(mem_wdata), 64'(sd[k]));
        end
      end else if (k < lc + rr) begin
        chk("run_busy", 64'(busy), 64'(1));
        chk("run_core_run", 64'(core_run), 64'(1));
        chk("run_ready", 64'(prog_ready), 64'(0));
        chk("run_we", 64'(mem_we), 64'(0));
        chk("run_count", 64'(cycle_count), 64'(k - lc));
      end else if (k < e_end) begin
        off = k - lc - rr;
        chk("chk_busy", 64'(busy), 64'(1));
        chk("chk_core_run", 64'(core_run), 64'(0));
        chk("chk_done", 64'(done), 64'(0));
        chk("chk_we", 64'(mem_we), 64'(0));
        if (n_en > 0 && off % 2 == 0)
          chk("chk_rd_addr", 64'(mem_addr), 64'(chk_addr[en_list[off/2]*ADDR_W +: ADDR_W]));
      end else begin
        chk("done_done", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_core_run", 64'(core_run), 64'(0));
        chk("done_we", 64'(mem_we), 64'(0));
        chk("done_pass", 64'(pass), 64'(exp_pass));
        chk("done_timed_out", 64'(timed_out), 64'(exp_to));
        chk("done_fail_idx", 64'(fail_idx), 64'(exp_fidx));
        chk("done_cycle_count", 64'(cycle_count), 64'(rr));
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_prog_ready"}, 64'(prog_ready), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_core_run"}, 64'(core_run), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_pass"}, 64'(pass), 64'(0));
    chk({tag, "_timed_out"}, 64'(timed_out), 64'(0));
    chk({tag, "_fail_idx"}, 64'(fail_idx), 64'(0));
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'(0));
  endtask

  task automatic set_slot(input int s, input int a, input logic [31:0] d);
    chk_addr[s*ADDR_W +: ADDR_W] = ADDR_W'(a);
    chk_data[s*DATA_W +: DATA_W] = d;
  endtask

  task automatic load_fact(input bit with_hlt);
    for (int b = 0; b < 11; b++) begin
      ba[b] = ADDR_W'(b);
      bd[b] = FACT_IMG[b];
    end
    if (!with_hlt) bd[9] = 32'h0800_0009;
    ba[11] = ADDR_W'(200);
    bd[11] = 32'd7;
    nbeats = 12;
  endtask

  // Gap cycles carry junk address/data/last that must not be written.
  task automatic build_sched(input bit alternate);
    lc = 0;
    for (int b = 0; b < nbeats; b++) begin
      int gaps;
      gaps = alternate ? ((b == 0) ? 0 : 1) : int'($urandom_range(0, 2));
      for (int g = 0; g < gaps; g++) begin
        sv[lc] = 1'b0;
        sa[lc] = ADDR_W'($urandom);
        sd[lc] = $urandom;
        sl[lc] = 1'($urandom_range(0, 1));
        lc++;
      end
      sv[lc] = 1'b1;
      sa[lc] = ba[b];
      sd[lc] = bd[b];
      sl[lc] = (b == nbeats - 1);
      lc++;
    end
  endtask

  // Reference model: final memory image and the phase lengths of the sequence.
  task automatic predict(input int hlt, input int tmo);
    logic [DATA_W-1:0] pm [MEM_D];
    int halt_cyc;
    for (int i = 0; i < MEM_D; i++) pm[i] = mem[i];
    for (int k = 0; k < lc; k++) if (sv[k]) pm[sa[k]] = sd[k];
    n_en = 0;
    for (int i = 0; i < NUM_CHECKS; i++) if (chk_en[i]) begin en_list[n_en] = i; n_en++; end
    halt_cyc = (hlt == 0) ? 1000000 : hlt + 1;
    exp_fidx = 0;
    if (tmo != 0 && tmo < halt_cyc) begin
      rr = tmo; exp_to = 1'b1; exp_pass = 1'b0; cc_len = 0;
    end else begin
      rr = halt_cyc; exp_to = 1'b0; exp_pass = 1'b1;
      pm[198] = fact32(pm[200]);
      cc_len = (n_en == 0) ? 1 : 2 * n_en;
      for (int j = 0; j < n_en; j++) begin
        int s;
        s = en_list[j];
        if (exp_pass && pm[chk_addr[s*ADDR_W +: ADDR_W]] != chk_data[s*DATA_W +: DATA_W]) begin
          exp_pass = 1'b0; exp_fidx = s; cc_len = 2 * (j + 1);
        end
      end
    end
    e_end = lc + rr + cc_len;
  endtask

  task automatic run_seq(input int hlt, input int tmo, input int reset_at, input bit start_in_run);
    active = 1'b0;
    halt_after = hlt;
    timeout_cycles = CNT_W'(tmo);
    predict(hlt, tmo);
    @(posedge clk1); #1;
    start = 1'b1;
    @(posedge clk1); #1;
    start = 1'b0;
    start_cyc = cyc;
    active = 1'b1;
    for (int k = 0; k < e_end + 3; k++) begin
      if (k < lc) begin
        prog_valid = sv[k]; prog_addr = sa[k]; prog_data = sd[k]; prog_last = sl[k];
      end else begin
        prog_valid = 1'($urandom_range(0, 1)); prog_addr = ADDR_W'($urandom);
        prog_data = $urandom; prog_last = 1'($urandom_range(0, 1));
      end
      start = start_in_run && (k == lc + rr / 2);
      if (k == reset_at) begin
        #3;
        active = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("rst_mid");
        @(posedge clk1); @(posedge clk1); #1;
        rst_n = 1'b1; start = 1'b0; prog_valid = 1'b0;
        return;
      end
      @(posedge clk1); #1;
    end
    start = 1'b0;
    prog_valid = 1'b0;
  endtask

  task automatic fact_checks(input logic [31:0] exp1);
    chk_en = 4'b0011;
    chk_addr = '0;
    chk_data = '0;
    set_slot(0, 200, 32'd7);
    set_slot(1, 198, exp1);
    set_slot(2, 5, 32'd1);
    set_slot(3, 6, 32'd2);
  endtask

  initial begin
    int hlt;
    rst_n = 1'b0; start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
    prog_addr = '0; prog_data = '0; timeout_cycles = '0;
    chk_en = '0; chk_addr = '0; chk_data = '0;
    repeat (3) @(posedge clk1);
    #1;
    check_reset("por");
    rst_n = 1'b1;
    @(posedge clk1); #1;
    check_reset("idle");

    // Factorial with prog_valid toggling every other cycle.
    load_fact(1'b1); fact_checks(32'd5040); build_sched(1'b1);
    run_seq(int'($urandom_range(20, 60)), 0, -1, 1'b0);
    chk("fact_done", 64'(done), 64'(1));
    chk("fact_pass", 64'(pass), 64'(1));
    chk("fact_timed_out", 64'(timed_out), 64'(0));
    chk("fact_count_nonzero", 64'(cycle_count != '0), 64'(1));
    chk("fact_mem198", 64'(mem[198]), 64'(5040));

    // Wrong expectation in slot 1.
    load_fact(1'b1); fact_checks(32'd5041); build_sched(1'b0);
    run_seq(int'($urandom_range(20, 60)), 0, -1, 1'b0);
    chk("wrong_pass", 64'(pass), 64'(0));
    chk("wrong_fail_idx", 64'(fail_idx), 64'(1));
    chk("wrong_timed_out", 64'(timed_out), 64'(0));

    // Program without HLT, 100-cycle timeout.
    load_fact(1'b0); fact_checks(32'd5040); build_sched(1'b0);
    run_seq(0, 100, -1, 1'b0);
    chk("tmo_timed_out", 64'(timed_out), 64'(1));
    chk("tmo_pass", 64'(pass), 64'(0));
    chk("tmo_cycle_count", 64'(cycle_count), 64'(100));

    // No slots enabled, start pulsed during RUN.
    load_fact(1'b1); fact_checks(32'd5040); chk_en = '0; build_sched(1'b0);
    run_seq(int'($urandom_range(10, 40)), 0, -1, 1'b1);
    chk("noslot_pass", 64'(pass), 64'(1));

    // Reset in RUN, then a normal sequence.
    load_fact(1'b1); fact_checks(32'd5040); build_sched(1'b0);
    run_seq(30, 0, lc + 5, 1'b0);
    build_sched(1'b0);
    run_seq(25, 0, -1, 1'b0);
    chk("after_rst_run_pass", 64'(pass), 64'(1));

    // Reset in CHK_CMP of slot 0, then a normal sequence.
    hlt = 20;
    build_sched(1'b0);
    run_seq(hlt, 0, lc + hlt + 1 + 1, 1'b0);
    build_sched(1'b1);
    run_seq(hlt, 0, -1, 1'b0);
    chk("after_rst_cmp_pass", 64'(pass), 64'(1));

    // HALTED and timeout in the same cycle: halted wins.
    build_sched(1'b0);
    run_seq(49, 50, -1, 1'b0);
    chk("tie_timed_out", 64'(timed_out), 64'(0));
    chk("tie_cycle_count", 64'(cycle_count), 64'(50));

    // Randomized programs, check slots, halt points and timeouts.
    for (int it = 0; it < 8; it++) begin
      int nb;
      nb = int'($urandom_range(2, 7));
      for (int b = 0; b < nb; b++) begin
        ba[b] = ADDR_W'(b * 13 + int'($urandom_range(0, 12)));
        bd[b] = $urandom;
      end
      ba[nb] = ADDR_W'(200);
      bd[nb] = 32'($urandom_range(0, 10));
      nbeats = nb + 1;
      chk_en = 4'($urandom_range(0, 15));
      for (int s = 0; s < NUM_CHECKS; s++) begin
        int pick;
        logic [31:0] e;
        pick = int'($urandom_range(0, nb));
        if (pick == nb) set_slot(s, 198, fact32(bd[nb]));
        else set_slot(s, int'(ba[pick]), bd[pick]);
        if ($urandom_range(0, 3) == 0) begin
          e = chk_data[s*DATA_W +: DATA_W] ^ 32'd1;
          chk_data[s*DATA_W +: DATA_W] = e;
        end
      end
      build_sched(1'($urandom_range(0, 1)));
      run_seq(int'($urandom_range(5, 60)),
              ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(3, 70)), -1, 1'b0);
    end

    active = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
